// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex glyph decoder for the 7-segment scan controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  // All segments off (active-low bus).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0-9, A, b, C, d, E, F.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Loadable down-counter; tc is high while the count sits at zero.
// The scan FSM reloads it on every phase change, so one counter times both phases.
module seg7_tick_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  // Count down to zero and hold; a load overrides the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {WIDTH{1'b0}};
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != {WIDTH{1'b0}}) begin
      cnt <= cnt - WIDTH'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign tc = (cnt == {WIDTH{1'b0}});

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment bank.
// A loaded value waits in a shadow register and is committed to the display
// register only when leaving IDLE or at a frame boundary, so a frame never mixes values.
// Optional feature: define SEG7_SCAN_LZB_EN for leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  output logic [6:0]                    seg_n,
  output logic                          dp_n,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // The counter is loaded with (cycles - 1) and the phase ends on its zero cycle.
  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  scan_state_t             state_r, state_nxt_s;
  logic [IDX_W-1:0]        idx_r, idx_nxt_s;
  logic                    cnt_load_s;
  logic [CNT_W-1:0]        cnt_val_s;
  logic [CNT_W-1:0]        cnt_s;
  logic                    tc_s;
  logic                    frame_pulse_s;
  logic                    commit_s;

  logic [4*NUM_DIGITS-1:0] shadow_val_r, disp_val_r;
  logic [NUM_DIGITS-1:0]   shadow_dp_r, disp_dp_r;
  logic                    pending_r;

  logic [NUM_DIGITS-1:0]   lz_blank_s;
  logic [3:0]              nib_s;
  logic [6:0]              seg_sel_s;

  seg7_tick_gen #(.WIDTH(CNT_W)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .cnt      (cnt_s),
    .tc       (tc_s)
  );

  // Scan sequencing: next state, next digit, counter reloads, frame boundary and commit.
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    cnt_load_s    = 1'b0;
    cnt_val_s     = {CNT_W{1'b0}};
    frame_pulse_s = 1'b0;
    commit_s      = 1'b0;
    if (!enable) begin
      state_nxt_s = IDLE;
      idx_nxt_s   = {IDX_W{1'b0}};
      cnt_load_s  = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = BLANK;
          idx_nxt_s   = {IDX_W{1'b0}};
          cnt_load_s  = 1'b1;
          cnt_val_s   = BLANK_LOAD;
          commit_s    = pending_r;
        end
        BLANK: begin
          if (tc_s) begin
            state_nxt_s = SHOW;
            cnt_load_s  = 1'b1;
            cnt_val_s   = SHOW_LOAD;
          end else begin
            state_nxt_s = BLANK;
          end
        end
        SHOW: begin
          if (tc_s) begin
            state_nxt_s = BLANK;
            cnt_load_s  = 1'b1;
            cnt_val_s   = BLANK_LOAD;
            if (idx_r == LAST_IDX) begin
              idx_nxt_s     = {IDX_W{1'b0}};
              frame_pulse_s = 1'b1;
              commit_s      = pending_r;
            end else begin
              idx_nxt_s = idx_r + IDX_W'(1);
            end
          end else begin
            state_nxt_s = SHOW;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          idx_nxt_s   = {IDX_W{1'b0}};
          cnt_load_s  = 1'b1;
        end
      endcase
    end
  end

  // FSM state and digit index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Shadow capture on load, display commit at frame boundary; a same-cycle load re-arms pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_val_r <= {(4*NUM_DIGITS){1'b0}};
      shadow_dp_r  <= {NUM_DIGITS{1'b0}};
      disp_val_r   <= {(4*NUM_DIGITS){1'b0}};
      disp_dp_r    <= {NUM_DIGITS{1'b0}};
      pending_r    <= 1'b0;
    end else begin
      if (load) begin
        shadow_val_r <= value;
        shadow_dp_r  <= dp_in;
      end else begin
        shadow_val_r <= shadow_val_r;
        shadow_dp_r  <= shadow_dp_r;
      end
      if (commit_s) begin
        disp_val_r <= shadow_val_r;
        disp_dp_r  <= shadow_dp_r;
      end else begin
        disp_val_r <= disp_val_r;
        disp_dp_r  <= disp_dp_r;
      end
      if (load) begin
        pending_r <= 1'b1;
      end else if (commit_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

`ifdef SEG7_SCAN_LZB_EN
  // Digit i is a leading zero when it and every higher nibble are zero; digit 0 always shows.
  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    lz_blank_s = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & (disp_val_r[4*i +: 4] == 4'h0);
      lz_blank_s[i] = zero_run & (i != 0);
    end
  end
`else
  assign lz_blank_s = {NUM_DIGITS{1'b0}};
`endif

  // Segment pattern for the currently selected digit.
  always_comb begin
    nib_s = disp_val_r[{idx_r, 2'b00} +: 4];
    if (lz_blank_s[idx_r]) begin
      seg_sel_s = SEG_BLANK;
    end else begin
      seg_sel_s = hex_to_seg(nib_s);
    end
  end

  // Registered pin drivers; disable darkens the bank at the same edge the FSM drops to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      an_n       <= {NUM_DIGITS{1'b1}};
      frame_done <= 1'b0;
    end else if (!enable) begin
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
      an_n       <= {NUM_DIGITS{1'b1}};
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_pulse_s;
      case (state_r)
        SHOW: begin
          seg_n <= seg_sel_s;
          dp_n  <= ~disp_dp_r[idx_r];
          an_n  <= ~(ONE_HOT0 << idx_r);
        end
        IDLE, BLANK: begin
          seg_n <= SEG_BLANK;
          dp_n  <= 1'b1;
          an_n  <= {NUM_DIGITS{1'b1}};
        end
        default: begin
          seg_n <= SEG_BLANK;
          dp_n  <= 1'b1;
          an_n  <= {NUM_DIGITS{1'b1}};
        end
      endcase
    end
  end

  assign digit_idx = idx_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (NUM_DIGITS=4, SHOW_CYCLES=4, BLANK_CYCLES=1).
// The reference model tracks the scan as a position within the frame and derives
// digit and phase by division; it also covers SEG7_SCAN_LZB_EN when defined.
module tb_seg7_scan_ctrl;

  localparam int N = 4;
  localparam int S = 4;
  localparam int B = 1;
  localparam int P = B + S;
  localparam int F = N * P;
  localparam logic [14:0] RESET_V = {7'h7F, 1'b1, 4'hF, 2'd0, 1'b0};

  logic        clk;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic [1:0]  digit_idx;
  logic        frame_done;

  logic [14:0] obs;
  logic [14:0] exp_v;
  int          checks;
  int          errors;
  int          cyc;

  // Model state: m_p = -1 when idle, else position within the frame.
  int          m_p;
  logic [15:0] m_sh_val, m_d_val;
  logic [3:0]  m_sh_dp, m_d_dp;
  logic        m_pend;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (N),
    .SHOW_CYCLES (S),
    .BLANK_CYCLES(B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .load      (load),
    .value     (value),
    .dp_in     (dp_in),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .an_n      (an_n),
    .digit_idx (digit_idx),
    .frame_done(frame_done)
  );

  assign obs = {seg_n, dp_n, an_n, digit_idx, frame_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] g;
    case (h)
      4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
      4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
      4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
      4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  4'hF: g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // One clock: predict the outputs from the model state the DUT saw, then advance the model.
  task automatic tick();
    int          d;
    int          ph;
    int          new_p;
    logic        commit;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic        e_fd;
    logic [15:0] upper;
    @(posedge clk);
    cyc++;
    e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0; commit = 1'b0;
    if (rst) begin
      m_p = -1; m_sh_val = 16'h0; m_sh_dp = 4'h0; m_d_val = 16'h0; m_d_dp = 4'h0; m_pend = 1'b0;
    end else begin
      if (!enable) begin
        new_p = -1;
      end else begin
        if (m_p >= 0) begin
          d  = m_p / P;
          ph = m_p % P;
          if (ph >= B) begin
            upper = m_d_val >> (4 * d);
            e_seg = glyph(upper[3:0]);
`ifdef SEG7_SCAN_LZB_EN
            if (d != 0 && upper == 16'h0) e_seg = 7'h7F;
`endif
            e_an = ~(4'b0001 << d);
            e_dp = ~m_d_dp[d];
          end
        end
        e_fd   = (m_p == F - 1);
        commit = (m_p < 0 || m_p == F - 1) && m_pend;
        new_p  = (m_p < 0) ? 0 : (m_p + 1) % F;
      end
      if (commit) begin
        m_d_val = m_sh_val;
        m_d_dp  = m_sh_dp;
      end
      if (load) begin
        m_sh_val = value;
        m_sh_dp  = dp_in;
        m_pend   = 1'b1;
      end else if (commit) begin
        m_pend = 1'b0;
      end
      m_p = new_p;
    end
    exp_v = {e_seg, e_dp, e_an, 2'((m_p < 0) ? 0 : m_p / P), e_fd};
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; load = 1'b0; value = 16'h0; dp_in = 4'h0;
    tick();
    checks++;
    if (obs !== RESET_V) begin
      errors++;
      $display("FAIL reset_state cyc=%0d got=%h required=%h", cyc, obs, RESET_V);
    end
    enable = 1'b1; load = 1'b1; value = 16'hFFFF;
    tick();
    checks++;
    if (obs !== RESET_V) begin
      errors++;
      $display("FAIL reset_priority cyc=%0d got=%h required=%h", cyc, obs, RESET_V);
    end
    rst = 1'b0; enable = 1'b0; load = 1'b0;
    tick();
  endtask

  task automatic test_scan_order();
    bit         found;
    logic [6:0] want_seg;
    logic [3:0] want_an;
    enable = 1'b1; load = 1'b1; value = 16'h12AF; dp_in = 4'h0;
    tick();
    load = 1'b0;
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL scan_start cyc=%0d got=%h required=%h", cyc, obs, exp_v);
    end
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL scan_first_frame cyc=%0d got=%h required=%h", cyc, obs, exp_v);
      end
      if (frame_done) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL scan_frame_done_timeout got=none required=pulse within 100 cycles");
    end
    for (int k = 0; k < F; k++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL scan_model cyc=%0d got=%h required=%h", cyc, obs, exp_v);
      end
      if (k % P < B) begin
        want_seg = 7'h7F;
        want_an  = 4'hF;
      end else begin
        want_an = ~(4'b0001 << (k / P));
        case (k / P)
          0:       want_seg = 7'h0E;
          1:       want_seg = 7'h08;
          2:       want_seg = 7'h24;
          default: want_seg = 7'h79;
        endcase
      end
      checks++;
      if ({seg_n, an_n} !== {want_seg, want_an}) begin
        errors++;
        $display("FAIL scan_walk k=%0d got seg=%h an=%b required seg=%h an=%b",
                 k, seg_n, an_n, want_seg, want_an);
      end
    end
  endtask

  task automatic test_midframe_load();
    bit found;
    int r;
    r = $urandom_range(3, 12);
    for (int c = 0; c < r; c++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL midload_pre cyc=%0d got=%h required=%h", cyc, obs, exp_v);
      end
    end
    load = 1'b1; value = 16'h0001; dp_in = 4'b0001;
    tick();
    load = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL midload_old_frame cyc=%0d got=%h required=%h", cyc, obs, exp_v);
      end
      if (frame_done) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midload_fd_timeout got=none required=pulse within 40 cycles");
    end
    tick();
    tick();
    checks++;
    if ({seg_n, dp_n, an_n} !== {7'h79, 1'b0, 4'b1110}) begin
      errors++;
      $display("FAIL midload_new_digit0 got=%h/%b/%b required=79/0/1110", seg_n, dp_n, an_n);
    end
  endtask

  task automatic test_boundary_load();
    bit found;
    load = 1'b1; value = 16'hC0DE; dp_in = 4'h0;
    tick();
    load = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (m_p == F - 1) begin
        found = 1'b1;
      end else begin
        tick();
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL bound_wait cyc=%0d got=%h required=%h", cyc, obs, exp_v);
        end
      end
    end
    load = 1'b1; value = 16'h4321;
    tick();
    load = 1'b0;
    checks++;
    if (frame_done !== 1'b1 || obs !== exp_v) begin
      errors++;
      $display("FAIL bound_commit_edge cyc=%0d got=%h required=%h", cyc, obs, exp_v);
    end
    tick();
    tick();
    checks++;
    if ({seg_n, an_n} !== {7'h06, 4'b1110}) begin
      errors++;
      $display("FAIL bound_old_shadow got=%h/%b required=06/1110", seg_n, an_n);
    end
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL bound_next_frame cyc=%0d got=%h required=%h", cyc, obs, exp_v);
      end
      if (frame_done) found = 1'b1;
    end
    tick();
    tick();
    checks++;
    if ({seg_n, an_n} !== {7'h79, 4'b1110}) begin
      errors++;
      $display("FAIL bound_new_shadow got=%h/%b required=79/1110", seg_n, an_n);
    end
  endtask

  task automatic test_disable();
    bit found;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (m_p / P == 2 && m_p % P >= B) begin
        found = 1'b1;
      end else begin
        tick();
      end
    end
    enable = 1'b0;
    tick();
    checks++;
    if (obs !== RESET_V) begin
      errors++;
      $display("FAIL disable_dark cyc=%0d got=%h required=%h", cyc, obs, RESET_V);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL disable_hold cyc=%0d got=%h required=%h", cyc, obs, exp_v);
      end
    end
    enable = 1'b1;
    tick();
    checks++;
    if (digit_idx !== 2'd0 || obs !== exp_v) begin
      errors++;
      $display("FAIL reenable_idx cyc=%0d got=%h required=%h", cyc, obs, exp_v);
    end
    tick();
    tick();
    checks++;
    if (an_n !== 4'b1110) begin
      errors++;
      $display("FAIL reenable_digit0 got=%b required=1110", an_n);
    end
  endtask

  task automatic test_reset_midscan();
    bit found;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (m_p >= 0 && m_p % P >= B) found = 1'b1;
      else tick();
    end
    rst = 1'b1; load = 1'b1; value = 16'($urandom); dp_in = 4'($urandom);
    tick();
    rst = 1'b0; load = 1'b0;
    checks++;
    if (obs !== RESET_V) begin
      errors++;
      $display("FAIL rst_midscan cyc=%0d got=%h required=%h", cyc, obs, RESET_V);
    end
    for (int c = 0; c < F + 5; c++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rst_load_discard cyc=%0d got=%h required=%h", cyc, obs, exp_v);
      end
    end
  endtask

`ifdef SEG7_SCAN_LZB_EN
  task automatic test_lzb();
    bit found;
    load = 1'b1; value = 16'h0000; dp_in = 4'h0;
    tick();
    load = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      tick();
      if (frame_done) found = 1'b1;
    end
    for (int k = 0; k < F; k++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL lzb_model k=%0d got=%h required=%h", k, obs, exp_v);
      end
      if (k == 1 || k == 16) begin
        checks++;
        if (seg_n !== ((k == 1) ? 7'h40 : 7'h7F)) begin
          errors++;
          $display("FAIL lzb_zero k=%0d got=%h required=%h", k, seg_n, (k == 1) ? 7'h40 : 7'h7F);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      rst    = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 59) != 0);
      load   = ($urandom_range(0, 24) == 0);
      value  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
      dp_in  = 4'($urandom);
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h required=%h", cyc, obs, exp_v);
      end
    end
    rst = 1'b0; load = 1'b0; enable = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; m_p = -1;
    rst = 1'b1; enable = 1'b0; load = 1'b0; value = 16'h0; dp_in = 4'h0;
    test_reset();
    test_scan_order();
    test_midframe_load();
    test_boundary_load();
    test_disable();
    test_reset_midscan();
`ifdef SEG7_SCAN_LZB_EN
    test_lzb();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
